mdu_ctrl: RTL
=============

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 md_op  input  4  E-stage op: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8; codes 9-15 = NONE.
REQ-006 rs_val  input  32  forwarded rs operand (dividend, multiplicand, mthi/mtlo source).
REQ-007 rt_val  input  32  forwarded rt operand (divisor, multiplier).
REQ-008 req  input  1  exception/interrupt flush; suppresses the E-stage op this cycle.
REQ-009 start  output  1  combinational; high when a mult/div is accepted this cycle.
REQ-010 busy  output  1  registered; high while an accepted mult/div is in flight.
REQ-011 md_stall  output  1  combinational stall request to the hazard unit.
REQ-012 md_out  output  32  combinational HI (MFHI) or LO (MFLO), else 0.

Function
REQ-013 start = (md_op in MULT..DIVU) & ~busy & ~req.
REQ-014 On start, operands are captured and the result is computed into shadow registers hi_nxt/lo_nxt in the same edge.
REQ-015 On start, counter loads MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu); busy rises the next cycle.
REQ-016 Counter decrements each cycle while busy; busy stays high exactly N cycles after the start cycle.
REQ-017 On the edge where counter goes 1->0, HI<=hi_nxt, LO<=lo_nxt and busy falls.
REQ-018 mult: signed 64-bit product, HI=[63:32], LO=[31:0]; multu: unsigned.
REQ-019 div: LO=signed quotient truncated toward zero, HI=remainder with sign of dividend; divu: unsigned.
REQ-020 div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-021 Divisor zero (div/divu): full DIV_CYCLES busy period runs; HI/LO unchanged at commit.
REQ-022 MTHI/MTLO: HI/LO <= rs_val at the edge when ~busy & ~req; suppressed while busy or req.
REQ-023 MFHI/MFLO: md_out reflects committed HI/LO; no bypass of shadow registers.
REQ-024 md_stall = (busy | start) & (md_op != NONE); start alone never stalls an op already accepted.
REQ-025 req while busy: in-flight op continues and commits; only the E-stage op is suppressed.
REQ-026 New mult/div while busy: not accepted; md_stall holds it until busy falls; accepted in the first cycle with busy=0.
REQ-027 Back-to-back: a mult/div presented in the cycle busy falls is accepted that cycle (no bubble).

Reset
REQ-028 Reset asserted: HI=0, LO=0, hi_nxt=0, lo_nxt=0, counter=0, busy=0, independent of clk.
REQ-029 Reset mid-operation aborts the op; no commit occurs after deassertion.
REQ-030 Outputs after reset: busy=0, start/md_stall per inputs, md_out=0 for MFHI/MFLO.

Structure
REQ-031 Shared package mdu_pkg holds the md_op encoding constants and default MULT_CYCLES/DIV_CYCLES.
REQ-032 One sub-module mdu_arith: combinational signed/unsigned multiply and divide, 64-bit {hi,lo} result.
REQ-033 mdu_ctrl holds counter, busy, shadow and HI/LO registers and all handshake logic.

Verification
REQ-034 MULT rs=0xFFFFFFFE (-2), rt=3, one cycle -> start=1; busy 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-035 DIVU rs=100, rt=7 then MFLO held -> md_stall=1 for 10 cycles; then md_out=14; MFHI gives 2.
REQ-036 DIV rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0; DIV by 0 with HI=5, LO=6 -> HI=5, LO=6 after 10 cycles.
REQ-037 MULT with req=1 -> start=0, busy stays 0, HI/LO unchanged; MTHI 0x1234 with req=1 -> HI unchanged.
REQ-038 MULTU started, reset pulsed low at busy cycle 3 -> busy=0, HI=LO=0 immediately and no later commit.
REQ-039 MULT held during busy of a prior DIV -> accepted in the cycle busy falls; its result commits 5 cycles later.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, default
// latencies and op classification helpers.
package mdu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] OP_NONE  = 4'd0;
  localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
  localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] OP_MFHI  = 4'd5;
  localparam logic [OP_W-1:0] OP_MFLO  = 4'd6;
  localparam logic [OP_W-1:0] OP_MTHI  = 4'd7;
  localparam logic [OP_W-1:0] OP_MTLO  = 4'd8;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // Ops that occupy the iterative unit (mult/multu/div/divu).
  function automatic logic is_md_op(input logic [OP_W-1:0] op);
    return (op >= OP_MULT) && (op <= OP_DIVU);
  endfunction

  // Any real MDU op; codes 9-15 decode as NONE.
  function automatic logic is_valid_op(input logic [OP_W-1:0] op);
    return (op >= OP_MULT) && (op <= OP_MTLO);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath.
// Ports:
//   op       - md_op code selecting mult/multu/div/divu
//   a, b     - rs (multiplicand/dividend) and rt (multiplier/divisor)
//   result   - {hi, lo}: product, or {remainder, quotient}
//   div_zero - divide op with a zero divisor (result not meaningful)
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [OP_W-1:0]     op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [2*DATA_W-1:0] result,
  output logic                div_zero
);

  logic                  is_signed;
  logic                  is_div;
  logic [2*DATA_W-1:0]   mul_a;
  logic [2*DATA_W-1:0]   mul_b;
  logic [2*DATA_W-1:0]   product;
  logic                  a_neg;
  logic                  b_neg;
  logic [DATA_W-1:0]     a_mag;
  logic [DATA_W-1:0]     b_mag;
  logic [DATA_W-1:0]     b_safe;
  logic [DATA_W-1:0]     q_mag;
  logic [DATA_W-1:0]     r_mag;
  logic [DATA_W-1:0]     quot;
  logic [DATA_W-1:0]     rem;

  // Extending to 64 bits first makes one truncated multiply serve both signednesses.
  // Division works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    is_div    = (op == OP_DIV) || (op == OP_DIVU);

    mul_a   = is_signed ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
    mul_b   = is_signed ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
    product = mul_a * mul_b;

    a_neg    = is_signed & a[DATA_W-1];
    b_neg    = is_signed & b[DATA_W-1];
    a_mag    = a_neg ? DATA_W'(-a) : a;
    b_mag    = b_neg ? DATA_W'(-b) : b;
    div_zero = is_div && (b == '0);
    b_safe   = (b == '0) ? DATA_W'(1) : b_mag;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    quot     = (a_neg ^ b_neg) ? DATA_W'(-q_mag) : q_mag;
    rem      = a_neg ? DATA_W'(-r_mag) : r_mag;

    result = is_div ? {rem, quot} : product;
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit control: accepts E-stage MDU ops, models the
// iterative latency with a down-counter, and commits results to HI/LO.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   md_op           - E-stage op code
//   rs_val, rt_val  - forwarded operands
//   req             - exception/interrupt flush of the E-stage op
//   start           - (comb) mult/div accepted this cycle
//   busy            - (reg) accepted mult/div in flight
//   md_stall        - (comb) stall request to the hazard unit
//   md_out          - (comb) committed HI for MFHI, LO for MFLO, else 0
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   md_op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              req,
  output logic              start,
  output logic              busy,
  output logic              md_stall,
  output logic [DATA_W-1:0] md_out
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0]      count;
  logic [DATA_W-1:0]     hi;
  logic [DATA_W-1:0]     lo;
  logic [DATA_W-1:0]     hi_nxt;
  logic [DATA_W-1:0]     lo_nxt;
  logic [2*DATA_W-1:0]   arith_result;
  logic                  div_zero;
  logic                  is_mult;

  mdu_arith u_arith (
    .op       (md_op),
    .a        (rs_val),
    .b        (rt_val),
    .result   (arith_result),
    .div_zero (div_zero)
  );

  assign is_mult  = (md_op == OP_MULT) || (md_op == OP_MULTU);
  assign start    = is_md_op(md_op) & ~busy & ~req;
  assign md_stall = (busy | start) & is_valid_op(md_op);

  // Read port sees only committed HI/LO.
  always_comb begin
    md_out = '0;
    case (md_op)
      OP_MFHI: md_out = hi;
      OP_MFLO: md_out = lo;
      default: md_out = '0;
    endcase
  end

  // Latency counter, shadow result and HI/LO.
  // A zero divisor snapshots current HI/LO so the commit leaves them unchanged;
  // MTHI/MTLO are locked out while busy, so the snapshot stays valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      busy   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      hi_nxt <= '0;
      lo_nxt <= '0;
    end else if (start) begin
      count <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      busy  <= 1'b1;
      if (div_zero) begin
        hi_nxt <= hi;
        lo_nxt <= lo;
      end else begin
        hi_nxt <= arith_result[2*DATA_W-1:DATA_W];
        lo_nxt <= arith_result[DATA_W-1:0];
      end
    end else if (busy) begin
      count <= count - CNT_W'(1);
      if (count == CNT_W'(1)) begin
        busy <= 1'b0;
        hi   <= hi_nxt;
        lo   <= lo_nxt;
      end
    end else if (!req) begin
      if (md_op == OP_MTHI) hi <= rs_val;
      if (md_op == OP_MTLO) lo <= rs_val;
    end
  end

endmodule
